// File: rtl/spi_master.sv
// SPI mode-0 master: one 8-bit frame per accepted start, MSB first, followed by a
// CLK_DIV-cycle slave-select gap. All serial outputs come straight from flops.
module spi_master #(
  parameter int   CLK_DIV         = 8,
  parameter logic CPOL0_IDLE_MOSI = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] din,
  output logic       busy,
  output logic       done,
  output logic [7:0] dout,
  output logic       ss,
  output logic       sck,
  output logic       mosi,
  input  logic       miso
);

  localparam int             CW       = $clog2(CLK_DIV + 1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(CLK_DIV - 1);

  typedef enum logic [1:0] {IDLE, XFER, GAP} state_t;

  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [3:0]    r_bits, w_bits_nxt;
  logic [6:0]    r_tx, w_tx_nxt;
  logic [7:0]    r_rx, w_rx_nxt;
  logic [7:0]    r_dout, w_dout_nxt;
  logic          r_ss, w_ss_nxt;
  logic          r_sck, w_sck_nxt;
  logic          r_mosi, w_mosi_nxt;
  logic          r_busy, w_busy_nxt;
  logic          r_done, w_done_nxt;
  logic          r_sync1, r_sync2;
  logic          w_tick;
  logic          w_accept;

  assign w_tick = (r_cnt == CNT_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_bits  <= '0;
      r_tx    <= '0;
      r_rx    <= '0;
      r_dout  <= '0;
      r_ss    <= 1'b1;
      r_sck   <= 1'b0;
      r_mosi  <= CPOL0_IDLE_MOSI;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_bits  <= w_bits_nxt;
      r_tx    <= w_tx_nxt;
      r_rx    <= w_rx_nxt;
      r_dout  <= w_dout_nxt;
      r_ss    <= w_ss_nxt;
      r_sck   <= w_sck_nxt;
      r_mosi  <= w_mosi_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      r_sync1 <= miso;
      r_sync2 <= r_sync1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_bits_nxt  = r_bits;
    w_tx_nxt    = r_tx;
    w_rx_nxt    = r_rx;
    w_dout_nxt  = r_dout;
    w_ss_nxt    = r_ss;
    w_sck_nxt   = r_sck;
    w_mosi_nxt  = r_mosi;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;
    w_accept    = 1'b0;

    case (r_state)
      IDLE: w_accept = start;
      XFER: begin
        if (w_tick) begin
          w_cnt_nxt = '0;
          if (!r_sck) begin
            w_sck_nxt  = 1'b1;
            w_rx_nxt   = {r_rx[6:0], r_sync2};
            w_bits_nxt = r_bits + 4'd1;
          end else if (r_bits == 4'd8) begin
            w_sck_nxt   = 1'b0;
            w_ss_nxt    = 1'b1;
            w_mosi_nxt  = CPOL0_IDLE_MOSI;
            w_dout_nxt  = r_rx;
            w_done_nxt  = 1'b1;
            w_state_nxt = GAP;
          end else begin
            w_sck_nxt  = 1'b0;
            w_mosi_nxt = r_tx[6];
            w_tx_nxt   = {r_tx[5:0], 1'b0};
          end
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      GAP: begin
        // The last gap cycle doubles as the first IDLE cycle so a held start
        // restarts with exactly CLK_DIV cycles of ss high.
        if (w_tick) begin
          w_cnt_nxt   = '0;
          w_busy_nxt  = 1'b0;
          w_state_nxt = IDLE;
          w_accept    = start;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase

    if (w_accept) begin
      w_state_nxt = XFER;
      w_ss_nxt    = 1'b0;
      w_busy_nxt  = 1'b1;
      w_mosi_nxt  = din[7];
      w_tx_nxt    = din[6:0];
      w_bits_nxt  = '0;
      w_cnt_nxt   = '0;
      w_sck_nxt   = 1'b0;
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign dout = r_dout;
  assign ss   = r_ss;
  assign sck  = r_sck;
  assign mosi = r_mosi;

endmodule

// File: doc/spi_master.md
SPI_MASTER -- requirements
Module: spi_master

Interface
REQ-001 The block SHALL have a parameter CLK_DIV, default 8, giving the SCK half-period in clk cycles; legal values are 8..255.
REQ-002 The block SHALL have a parameter CPOL0_IDLE_MOSI, default 1'b0, giving the MOSI level while ss is high.
REQ-003 clk  input  1  single system clock; all state advances on its rising edge.
REQ-004 rst  input  1  reset, asynchronous assert, active-low (0 = reset).
REQ-005 start  input  1  request one 8-bit frame; sampled only in IDLE.
REQ-006 din  input  8  byte to transmit; captured in the cycle start is accepted.
REQ-007 busy  output  1  high from frame acceptance until return to IDLE.
REQ-008 done  output  1  one-cycle pulse; dout is valid in that cycle.
REQ-009 dout  output  8  last received byte; holds until the next done.
REQ-010 ss  output  1  slave select, active-low.
REQ-011 sck  output  1  serial clock, idle low (mode 0).
REQ-012 mosi  output  1  serial data out, MSB first.
REQ-013 miso  input  1  serial data in, asynchronous to clk.

Function
REQ-014 The block SHALL use the states IDLE, XFER and GAP.
REQ-015 IDLE: if start=1 at edge T, the block SHALL set ss=0, busy=1 and mosi=din[7], load din[6:0] into the TX shift register, clear the bit counter and enter XFER.
REQ-016 start=0 in IDLE SHALL leave all outputs unchanged; start in XFER or GAP SHALL be ignored and not queued.
REQ-017 XFER: a half-period counter SHALL toggle sck every CLK_DIV cycles; the first rise is at T+CLK_DIV and the 16th toggle (final fall) at T+16*CLK_DIV.
REQ-018 On each sck rise, the block SHALL shift miso_s (miso through a 2-flop synchroniser) into the RX shift register LSB, and the oldest bit SHALL move toward the MSB.
REQ-019 On each sck fall except the 16th toggle, the block SHALL drive the next TX bit on mosi.
REQ-020 On the 16th toggle, the block SHALL set sck=0, ss=1, mosi=CPOL0_IDLE_MOSI, dout=RX register, done=1 for that cycle only, and enter GAP.
REQ-021 GAP: ss SHALL stay high for CLK_DIV cycles with busy=1; busy SHALL fall at T+17*CLK_DIV on entry to IDLE.
REQ-022 A new start SHALL be accepted in the first IDLE cycle, giving a minimum frame spacing of 17*CLK_DIV cycles.
REQ-023 The bit counter SHALL count rising edges 0..8 and SHALL NOT wrap within a frame.
REQ-024 The half-period counter SHALL be ceil(log2(CLK_DIV+1)) bits wide and reload to 0 on every sck toggle and on each state change.
REQ-025 sck, ss and mosi SHALL be driven directly from flops, with no glitches.

Reset
REQ-026 rst=0 SHALL immediately force: state=IDLE, ss=1, sck=0, mosi=CPOL0_IDLE_MOSI, busy=0, done=0, dout=8'h00, shift registers, counters and synchroniser = 0.
REQ-027 Reset asserted mid-frame SHALL abort the frame, produce no done pulse and leave dout at 8'h00.
REQ-028 After rst is released, the first start SHALL be accepted on the first clk edge with start=1.

Verification
REQ-029 Loopback (mosi tied to miso), CLK_DIV=8, din=8'hA5, start at T -> mosi carries 1,0,1,0,0,1,0,1 at rises T+8, T+24, ..., T+120; done at T+128 with dout=8'hA5; busy low at T+136.
REQ-030 Paired with the team's SPI slave (slave din=8'h3C), master din=8'hC3 -> master dout=8'h3C and slave dout=8'hC3, both done pulses within the same frame.
REQ-031 start held high continuously with din=8'h01, then 8'h02 -> two frames, ss high for exactly 8 cycles between them, no extra frame.
REQ-032 start pulsed at T+40 during XFER -> ignored, sck and mosi pattern identical to an undisturbed frame, a single done.
REQ-033 rst=0 at T+60 mid-frame -> ss=1 and sck=0 with no clock edge needed, no done, dout=8'h00; a fresh frame after release completes correctly.
REQ-034 CLK_DIV=255, din=8'hFF with miso=0 -> exactly 8 sck pulses of 510-cycle period, dout=8'h00, done at T+4080.
